sram_bridge: RTL



---
 rtl/sram_bridge_if.sv | 25 ++
 rtl/sram_bridge.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/sram_bridge_if.sv
// sram_bridge_if: CPU-side request/response bundle for sram_bridge
//   master: drives req_valid/req_we/req_addr/req_wdata/req_be, observes req_ready/resp_valid/resp_rdata
//   slave : the bridge side of the same signals
interface sram_bridge_if #(
  parameter int CPU_DW = 32,
  parameter int AW     = 18
);
  localparam int BB = $clog2(CPU_DW / 16);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [AW-BB-1:0]      req_addr;
  logic [CPU_DW-1:0]     req_wdata;
  logic [CPU_DW/8-1:0]   req_be;
  logic                  resp_valid;
  logic [CPU_DW-1:0]     resp_rdata;
  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be,
    input  req_ready, resp_valid, resp_rdata
  );
  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be,
    output req_ready, resp_valid, resp_rdata
  );
endinterface

// File: rtl/sram_bridge.sv
// sram_bridge: splits CPU word accesses into 16-bit async SRAM beats with byte enables and wait states
//   clockFast : single clock, rising edge
//   reset     : asynchronous, active-low
//   cpu       : sram_bridge_if.slave request/response port
//   addr/data/wre/oute/hb_mask/lb_mask/chip_en : SRAM pins, all strobes active-low, data tri-stated when idle
//   Optional: define SRAM_BEAT_SKIP_EN to skip beats whose two byte enables are both 0
module sram_bridge #(
  parameter int CPU_DW      = 32,
  parameter int AW          = 18,
  parameter int WAIT_STATES = 1
) (
  input  logic          clockFast,
  input  logic          reset,
  sram_bridge_if.slave  cpu,
  output logic [AW-1:0] addr,
  inout  wire  [15:0]   data,
  output logic          wre,
  output logic          oute,
  output logic          hb_mask,
  output logic          lb_mask,
  output logic          chip_en
);
  localparam int BEATS = CPU_DW / 16;
  localparam int BB    = $clog2(BEATS);
  localparam int KW    = BB > 0 ? BB : 1;
  localparam int BEW   = CPU_DW / 8;
`ifdef SRAM_BEAT_SKIP_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ADDR   = 2'd1;
  localparam logic [1:0] STROBE = 2'd2;
  localparam logic [1:0] RESP   = 2'd3;

  // {found, index} of the first beat at or after s that must run; without skipping that is simply s
  function automatic logic [KW:0] next_beat(input logic [BEW-1:0] be, input int s);
    logic [KW:0] r;
    r = '0;
    for (int i = BEATS - 1; i >= 0; i--)
      if (i >= s && (!SKIP || |be[2*i +: 2])) r = {1'b1, KW'(i)};
    return r;
  endfunction

  logic [1:0]        state_q, state_d;
  logic              we_q, we_d;
  logic [AW-BB-1:0]  word_q, word_d;
  logic [CPU_DW-1:0] wdata_q, wdata_d, rdata_q, rdata_d, resp_rdata_q;
  logic [BEW-1:0]    be_q, be_d;
  logic [KW-1:0]     k_q, k_d;
  logic [3:0]        wait_q, wait_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [15:0]       dout_q, dout_d;
  logic              drive_q, drive_d, wre_q, wre_d, oute_q, oute_d;
  logic              hb_q, hb_d, lb_q, lb_d, ce_q, ce_d, resp_valid_q;
  logic [KW:0]       nb;
  logic              act;

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    word_d  = word_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    k_d     = k_q;
    wait_d  = wait_q;
    rdata_d = rdata_q;
    nb      = '0;
    case (state_q)
      IDLE: if (cpu.req_valid) begin
        we_d    = cpu.req_we;
        word_d  = cpu.req_addr;
        wdata_d = cpu.req_wdata;
        be_d    = cpu.req_be;
        rdata_d = cpu.req_we ? rdata_q : '0;
        nb      = next_beat(cpu.req_be, 0);
        k_d     = nb[KW-1:0];
        state_d = nb[KW] ? ADDR : RESP;
      end
      ADDR: begin
        state_d = STROBE;
        wait_d  = 4'(WAIT_STATES);
      end
      STROBE: if (wait_q != 4'd0) wait_d = wait_q - 4'd1;
      else begin
        if (!we_q)
          rdata_d[{k_q, 4'b0} +: 16] = data & {{8{be_q[{k_q, 1'b1}]}}, {8{be_q[{k_q, 1'b0}]}}};
        nb      = next_beat(be_q, int'(k_q) + 1);
        k_d     = nb[KW] ? nb[KW-1:0] : k_q;
        state_d = nb[KW] ? ADDR : RESP;
      end
      default: state_d = IDLE;
    endcase
    // SRAM pins are registered, so they are computed from the state being entered
    act     = state_d == ADDR || state_d == STROBE;
    addr_d  = act ? (AW'(word_d) << BB) | AW'(k_d) : addr_q;
    ce_d    = !act;
    hb_d    = act ? ~be_d[{k_d, 1'b1}] : 1'b1;
    lb_d    = act ? ~be_d[{k_d, 1'b0}] : 1'b1;
    wre_d   = !(state_d == STROBE && we_d);
    oute_d  = !(state_d == STROBE && !we_d);
    drive_d = act && we_d;
    dout_d  = drive_d ? wdata_d[{k_d, 4'b0} +: 16] : dout_q;
  end

  always_ff @(posedge clockFast or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      we_q         <= 1'b0;
      word_q       <= '0;
      wdata_q      <= '0;
      be_q         <= '0;
      k_q          <= '0;
      wait_q       <= '0;
      rdata_q      <= '0;
      addr_q       <= '0;
      dout_q       <= '0;
      drive_q      <= 1'b0;
      wre_q        <= 1'b1;
      oute_q       <= 1'b1;
      hb_q         <= 1'b1;
      lb_q         <= 1'b1;
      ce_q         <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      we_q         <= we_d;
      word_q       <= word_d;
      wdata_q      <= wdata_d;
      be_q         <= be_d;
      k_q          <= k_d;
      wait_q       <= wait_d;
      rdata_q      <= rdata_d;
      addr_q       <= addr_d;
      dout_q       <= dout_d;
      drive_q      <= drive_d;
      wre_q        <= wre_d;
      oute_q       <= oute_d;
      hb_q         <= hb_d;
      lb_q         <= lb_d;
      ce_q         <= ce_d;
      resp_valid_q <= state_q == RESP;
      resp_rdata_q <= state_q == RESP ? rdata_q : resp_rdata_q;
    end
  end

  assign data           = drive_q ? dout_q : 16'hzzzz;
  assign addr           = addr_q;
  assign wre            = wre_q;
  assign oute           = oute_q;
  assign hb_mask        = hb_q;
  assign lb_mask        = lb_q;
  assign chip_en        = ce_q;
  assign cpu.req_ready  = state_q == IDLE && reset;
  assign cpu.resp_valid = resp_valid_q;
  assign cpu.resp_rdata = resp_rdata_q;
endmodule
